// File: rtl/mdu_iter_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// divide iteration count and a two's-complement magnitude helper.
package mdu_iter_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } mdu_state_e;

  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned CntW       = 5;

  // 0x80000000 maps to itself, which the divider treats as the unsigned magnitude 2^31.
  function automatic logic [31:0] absVal(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
`timescale 1ns/1ps
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module mdu_div_step (
  input  logic [31:0] remIn,
  input  logic        dividendBit,
  input  logic [31:0] divisor,
  output logic [31:0] remOut,
  output logic        quotBit
);

  logic [32:0] shifted;
  logic [32:0] trial;

  assign shifted = {remIn, dividendBit};
  assign trial   = shifted - {1'b0, divisor};
  // The partial remainder stays below the divisor, so bit 32 of the trial is a pure borrow.
  assign quotBit = ~trial[32];
  assign remOut  = quotBit ? trial[31:0] : shifted[31:0];

endmodule

// File: rtl/mdu_iter.sv
`timescale 1ns/1ps
// Multi-cycle multiply/divide unit owning HI/LO. Ready low stalls the front of the
// pipeline; results commit to HI/LO on the edge that leaves DONE.
module mdu_iter #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  MDUOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        ExceptDealM,
  input  logic        DataStall,
  output logic        MDUReadyE,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut
);
  import mdu_iter_pkg::*;

  mdu_state_e       stateQ, stateD;
  logic [CntW-1:0]  cntQ, cntD;
  logic [31:0]      opAQ, opAD, opBQ, opBD;
  logic [31:0]      remQ, remD, quotQ, quotD;
  logic [31:0]      resHiQ, resHiD, resLoQ, resLoD;
  logic [31:0]      hiQ, hiD, loQ, loD;
  logic             mulSignedQ, mulSignedD;
  logic             negQuotQ, negQuotD, negRemQ, negRemD;

  logic             isMulOp, isDivOp, divSigned;
  logic [63:0]      prodA, prodB, prod;
  logic [31:0]      remNext, quotNext;
  logic             quotBit;

  assign isMulOp   = (MDUOpE == MDU_MULT) || (MDUOpE == MDU_MULTU);
  assign isDivOp   = (MDUOpE == MDU_DIV) || (MDUOpE == MDU_DIVU);
  assign divSigned = (MDUOpE == MDU_DIV);

  assign MDUReadyE = ((stateQ == StIdle) && !(isMulOp || isDivOp)) || (stateQ == StDone);
  assign HiOut     = hiQ;
  assign LoOut     = loQ;

  // Extending to 64 bits gives the same low 64 product bits as a 33x33 signed multiply.
  assign prodA = {{32{mulSignedQ & opAQ[31]}}, opAQ};
  assign prodB = {{32{mulSignedQ & opBQ[31]}}, opBQ};
  assign prod  = prodA * prodB;

  mdu_div_step u_div_step (
    .remIn      (remQ),
    .dividendBit(quotQ[31]),
    .divisor    (opBQ),
    .remOut     (remNext),
    .quotBit    (quotBit)
  );

  assign quotNext = {quotQ[30:0], quotBit};

  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    opAD       = opAQ;
    opBD       = opBQ;
    remD       = remQ;
    quotD      = quotQ;
    resHiD     = resHiQ;
    resLoD     = resLoQ;
    hiD        = hiQ;
    loD        = loQ;
    mulSignedD = mulSignedQ;
    negQuotD   = negQuotQ;
    negRemD    = negRemQ;

    unique case (stateQ)
      StIdle: begin
        if (!ExceptDealM) begin
          if (isMulOp) begin
            opAD       = SrcAE;
            opBD       = SrcBE;
            mulSignedD = (MDUOpE == MDU_MULT);
            cntD       = CntW'(MUL_CYCLES - 1);
            stateD     = StMul;
          end else if (isDivOp) begin
            // quotD starts as the dividend and fills with quotient bits as it shifts out.
            quotD    = divSigned ? absVal(SrcAE) : SrcAE;
            opBD     = divSigned ? absVal(SrcBE) : SrcBE;
            remD     = '0;
            negQuotD = divSigned & (SrcAE[31] ^ SrcBE[31]);
            negRemD  = divSigned & SrcAE[31];
            cntD     = CntW'(DIV_CYCLES - 1);
            stateD   = StDiv;
          end else if (!DataStall) begin
            if (MDUOpE == MDU_MTHI) hiD = SrcAE;
            if (MDUOpE == MDU_MTLO) loD = SrcAE;
          end
        end
      end
      StMul: begin
        if (ExceptDealM) begin
          stateD = StIdle;
        end else begin
          resHiD = prod[63:32];
          resLoD = prod[31:0];
          if (cntQ == '0) stateD = StDone;
          else            cntD   = cntQ - 1'b1;
        end
      end
      StDiv: begin
        if (ExceptDealM) begin
          stateD = StIdle;
        end else begin
          remD  = remNext;
          quotD = quotNext;
          if (cntQ == '0) begin
            resLoD = negQuotQ ? -quotNext : quotNext;
            resHiD = negRemQ  ? -remNext  : remNext;
            stateD = StDone;
          end else begin
            cntD = cntQ - 1'b1;
          end
        end
      end
      StDone: begin
        if (ExceptDealM) begin
          stateD = StIdle;
        end else if (!DataStall) begin
          hiD    = resHiQ;
          loD    = resLoQ;
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateQ     <= StIdle;
      cntQ       <= '0;
      opAQ       <= '0;
      opBQ       <= '0;
      remQ       <= '0;
      quotQ      <= '0;
      resHiQ     <= '0;
      resLoQ     <= '0;
      hiQ        <= '0;
      loQ        <= '0;
      mulSignedQ <= 1'b0;
      negQuotQ   <= 1'b0;
      negRemQ    <= 1'b0;
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      opAQ       <= opAD;
      opBQ       <= opBD;
      remQ       <= remD;
      quotQ      <= quotD;
      resHiQ     <= resHiD;
      resLoQ     <= resLoD;
      hiQ        <= hiD;
      loQ        <= loD;
      mulSignedQ <= mulSignedD;
      negQuotQ   <= negQuotD;
      negRemQ    <= negRemD;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
`timescale 1ns/1ps
// Scoreboard bench for mdu_iter: expected HI/LO pairs are queued at issue and
// compared after the DONE-exit edge, alongside latency, stall and flush checks.
module tb_mdu_iter;

  localparam logic [2:0] OpNone  = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  MDUOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        ExceptDealM, DataStall;
  logic        MDUReadyE;
  logic [31:0] HiOut, LoOut;

  int          nTests = 0;
  int          nFail  = 0;
  logic [31:0] hiM = '0, loM = '0;
  logic [63:0] sb[$];

  mdu_iter #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .MDUOpE     (MDUOpE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .ExceptDealM(ExceptDealM),
    .DataStall  (DataStall),
    .MDUReadyE  (MDUReadyE),
    .HiOut      (HiOut),
    .LoOut      (LoOut)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent behavioural reference: {HI, LO}.
  function automatic logic [63:0] refOp(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint p;
    int     q, r;
    case (op)
      OpMult: begin
        p = longint'(int'(a)) * longint'(int'(b));
        return 64'(p);
      end
      OpMultu: return {32'd0, a} * {32'd0, b};
      OpDivu:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      OpDiv: begin
        if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {32'(r), 32'(q)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    MDUOpE = op;
    SrcAE  = a;
    SrcBE  = b;
    #1;
  endtask

  // Operands are scrambled after the first cycle since the unit must have latched them.
  task automatic waitReady(output int lat);
    lat = 0;
    while (!MDUReadyE && lat < 100) begin
      lat++;
      @(posedge clk); #1;
      SrcAE = $urandom;
      SrcBE = $urandom;
      #1;
    end
  endtask

  task automatic commit(input string tag);
    logic [63:0] exp;
    @(posedge clk); #1;
    MDUOpE = OpNone;
    #1;
    if (sb.size() == 0) begin
      checkEq({tag, "_sbempty"}, 64'd1, 64'd0);
    end else begin
      exp = sb.pop_front();
      hiM = exp[63:32];
      loM = exp[31:0];
      checkEq(tag, {HiOut, LoOut}, exp);
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int expLat);
    int lat;
    sb.push_back(exp);
    issue(op, a, b);
    waitReady(lat);
    checkEq({tag, "_lat"}, 64'(lat), 64'(expLat));
    checkEq({tag, "_hold"}, {HiOut, LoOut}, {hiM, loM});
    commit(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    resetn = 1'b0; MDUOpE = OpNone; SrcAE = '0; SrcBE = '0;
    ExceptDealM = 1'b0; DataStall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkEq("rst_ready", 64'(MDUReadyE), 64'd1);
    checkEq("rst_hilo", {HiOut, LoOut}, 64'd0);
    resetn = 1'b1;

    runOp("mult",  OpMult,  32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 3);
    runOp("multu", OpMultu, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, 3);
    runOp("div",   OpDiv,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    runOp("div2",  OpDiv,   32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
    runOp("divu",  OpDivu,  32'd100, 32'd7, {32'd2, 32'd14}, 33);
    runOp("divu0", OpDivu,  32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 33);
    runOp("divov", OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    runOp("div0s", OpDiv,   32'hFFFF_FFF8, 32'd0, {32'hFFFF_FFF8, 32'd1}, 33);

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      runOp($sformatf("rnd%0d", i), rop, ra, rb, refOp(rop, ra, rb),
            (rop == OpMult || rop == OpMultu) ? 3 : 33);
    end

    // Flush mid-divide: no commit, ready returns at once.
    issue(OpDiv, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    ExceptDealM = 1'b1;
    MDUOpE      = OpNone;
    #1;
    checkEq("flush_busy", 64'(MDUReadyE), 64'd0);
    @(posedge clk); #1;
    ExceptDealM = 1'b0;
    #1;
    checkEq("flush_ready", 64'(MDUReadyE), 64'd1);
    checkEq("flush_hilo", {HiOut, LoOut}, {hiM, loM});
    repeat (35) @(posedge clk);
    #1;
    checkEq("flush_late", {HiOut, LoOut}, {hiM, loM});

    // DONE held by DataStall: ready high, no commit until the stall drops.
    sb.push_back({32'd2, 32'd14});
    issue(OpDivu, 32'd100, 32'd7);
    waitReady(lat);
    checkEq("stall_lat", 64'(lat), 64'd33);
    DataStall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1; #1;
      checkEq($sformatf("stall_rdy%0d", k), 64'(MDUReadyE), 64'd1);
      checkEq($sformatf("stall_hl%0d", k), {HiOut, LoOut}, {hiM, loM});
    end
    DataStall = 1'b0;
    commit("stall_commit");
    @(posedge clk); #1; #1;
    checkEq("stall_norestart", 64'(MDUReadyE), 64'd1);

    // MTHI only writes on a non-stalled, non-flushed edge.
    @(posedge clk); #1;
    MDUOpE = OpMthi; SrcAE = 32'h1234_5678; DataStall = 1'b1;
    #1;
    checkEq("mthi_ready", 64'(MDUReadyE), 64'd1);
    @(posedge clk); #1;
    DataStall = 1'b0;
    #1;
    checkEq("mthi_stalled", 64'(HiOut), 64'(hiM));
    @(posedge clk); #1;
    MDUOpE = OpNone;
    hiM = 32'h1234_5678;
    #1;
    checkEq("mthi", 64'(HiOut), 64'(hiM));

    @(posedge clk); #1;
    MDUOpE = OpMtlo; SrcAE = 32'hCAFE_F00D; ExceptDealM = 1'b1;
    @(posedge clk); #1;
    ExceptDealM = 1'b0;
    #1;
    checkEq("mtlo_flushed", 64'(LoOut), 64'(loM));
    @(posedge clk); #1;
    MDUOpE = OpNone;
    loM = 32'hCAFE_F00D;
    #1;
    checkEq("mtlo", 64'(LoOut), 64'(loM));

    // Async reset in the middle of a multiply.
    issue(OpMult, 32'd7, 32'd9);
    @(posedge clk); #1;
    resetn = 1'b0;
    MDUOpE = OpNone;
    #1;
    checkEq("rstmul_ready", 64'(MDUReadyE), 64'd1);
    checkEq("rstmul_hilo", {HiOut, LoOut}, 64'd0);
    hiM = '0;
    loM = '0;
    @(posedge clk); #1;
    resetn = 1'b1;

    runOp("post_rst", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 3);

    checkEq("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
